// File: rtl/id_stage_pipe.sv
// id_stage_pipe - MIPS decode stage with the ID/EX pipeline register.
//
// Purpose:
//   Splits instr_d into its fields and reads the register file for rs and rt.
//   A write-back to the same register in the same cycle is forwarded into the
//   read data. A load in EX whose destination matches rs or rt is a load-use
//   hazard: the stage asks IF/ID to stall and sends a bubble into EX. All
//   results go into the ID/EX register, which has hold and flush control.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_d/instr_valid_d instruction in ID and its valid flag
//   cs_d                  external control bundle for instr_d, passed through
//   wb_we/wb_addr/wb_data register-file write port from write-back
//   ex_mem_read/ex_dst    load-in-EX flag and its destination register
//   hold                  downstream stall; the ID/EX register keeps its value
//   flush                 squash the instruction in ID
//   stall_id              combinational; IF/ID and PC must hold
//   ex_*                  ID/EX register outputs

module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_AD   = 5,
    parameter int CS_W     = 16,
    parameter bit SEXT_IMM = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] instr_d,
    input  logic              instr_valid_d,
    input  logic [CS_W-1:0]   cs_d,
    input  logic              wb_we,
    input  logic [REG_AD-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_mem_read,
    input  logic [REG_AD-1:0] ex_dst,
    input  logic              hold,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [CS_W-1:0]   ex_cs,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [REG_AD-1:0] ex_rs,
    output logic [REG_AD-1:0] ex_rt,
    output logic [REG_AD-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_imm,
    output logic [25:0]       ex_index
);

    localparam int NREG = 1 << REG_AD;

    // Field extraction; addresses wider than 5 bits are zero-padded.
    logic [REG_AD-1:0] rs, rt, rd;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] imm_ext;

    assign rs    = REG_AD'(instr_d[25:21]);
    assign rt    = REG_AD'(instr_d[20:16]);
    assign rd    = REG_AD'(instr_d[15:11]);
    assign imm16 = instr_d[15:0];

    always_comb begin
        if (SEXT_IMM) imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
        else          imm_ext = {{(DATA_W-16){1'b0}}, imm16};
    end

    // Register file. Entry 0 is never written, so it reads 0 from reset onward.
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic              wb_hit;

    assign wb_hit = wb_we && (wb_addr != '0);

    always_comb begin
        rf_d = rf_q;
        if (wb_hit) rf_d[wb_addr] = wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // Write-back bypass, so a read in the same cycle as the write sees the new value.
    logic [DATA_W-1:0] rs_data, rt_data;

    assign rs_data = (wb_hit && (wb_addr == rs)) ? wb_data : rf_q[rs];
    assign rt_data = (wb_hit && (wb_addr == rt)) ? wb_data : rf_q[rt];

    // Load-use hazard. rt is compared even for formats that do not read it.
    logic hazard;

    assign hazard   = instr_valid_d && ex_mem_read && (ex_dst != '0) &&
                      ((ex_dst == rs) || (ex_dst == rt));
    assign stall_id = hold || (hazard && !flush);

    // ID/EX register
    logic              ex_valid_q,   ex_valid_d;
    logic [CS_W-1:0]   ex_cs_q,      ex_cs_d;
    logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [REG_AD-1:0] ex_rs_q,      ex_rs_d;
    logic [REG_AD-1:0] ex_rt_q,      ex_rt_d;
    logic [REG_AD-1:0] ex_rd_q,      ex_rd_d;
    logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
    logic [25:0]       ex_index_q,   ex_index_d;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_cs_d      = ex_cs_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_rd_d      = ex_rd_q;
        ex_imm_d     = ex_imm_q;
        ex_index_d   = ex_index_q;
        if (!hold) begin
            if (flush) begin
                ex_valid_d   = 1'b0;
                ex_cs_d      = '0;
                ex_rs_data_d = '0;
                ex_rt_data_d = '0;
                ex_rs_d      = '0;
                ex_rt_d      = '0;
                ex_rd_d      = '0;
                ex_imm_d     = '0;
                ex_index_d   = '0;
            end else if (hazard) begin
                // Bubble: clearing cs keeps EX from acting on stale controls.
                ex_valid_d = 1'b0;
                ex_cs_d    = '0;
            end else begin
                ex_valid_d   = instr_valid_d;
                ex_cs_d      = cs_d;
                ex_rs_data_d = rs_data;
                ex_rt_data_d = rt_data;
                ex_rs_d      = rs;
                ex_rt_d      = rt;
                ex_rd_d      = rd;
                ex_imm_d     = imm_ext;
                ex_index_d   = instr_d[25:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_cs_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_imm_q     <= '0;
            ex_index_q   <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_cs_q      <= ex_cs_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_imm_q     <= ex_imm_d;
            ex_index_q   <= ex_index_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_cs      = ex_cs_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rt_data = ex_rt_data_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_rd      = ex_rd_q;
    assign ex_imm     = ex_imm_q;
    assign ex_index   = ex_index_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe - directed-vector bench for id_stage_pipe.
//
// Purpose:
//   Drives hand-built instructions and compares the ID/EX outputs with
//   expected values computed by hand. Inputs change 1 ns after a rising
//   edge, and outputs are sampled before the next edge. A second instance
//   with SEXT_IMM = 0 shares the inputs so the zero-extended immediate can
//   be checked.

module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        instr_valid_d;
    logic [15:0] cs_d;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_dst;
    logic        hold;
    logic        flush;

    logic        stall_id, ex_valid;
    logic [15:0] ex_cs;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [25:0] ex_index;

    logic        z_stall_id, z_ex_valid;
    logic [15:0] z_ex_cs;
    logic [31:0] z_ex_rs_data, z_ex_rt_data, z_ex_imm;
    logic [4:0]  z_ex_rs, z_ex_rt, z_ex_rd;
    logic [25:0] z_ex_index;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.SEXT_IMM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .instr_valid_d(instr_valid_d),
        .cs_d(cs_d), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .hold(hold), .flush(flush),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_cs(ex_cs),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_index(ex_index)
    );

    id_stage_pipe #(.SEXT_IMM(1'b0)) dut_zext (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .instr_valid_d(instr_valid_d),
        .cs_d(cs_d), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .hold(hold), .flush(flush),
        .stall_id(z_stall_id), .ex_valid(z_ex_valid), .ex_cs(z_ex_cs),
        .ex_rs_data(z_ex_rs_data), .ex_rt_data(z_ex_rt_data), .ex_rs(z_ex_rs),
        .ex_rt(z_ex_rt), .ex_rd(z_ex_rd), .ex_imm(z_ex_imm), .ex_index(z_ex_index)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 11'h000};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
        return {6'h23, rs, rt, imm};
    endfunction

    initial begin
        rst_n = 1'b0; instr_d = '0; instr_valid_d = 1'b0; cs_d = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        ex_mem_read = 1'b0; ex_dst = '0; hold = 1'b0; flush = 1'b0;

        #2;
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_ex_cs", 32'(ex_cs), 32'h0);
        chk("rst_ex_rs_data", ex_rs_data, 32'h0);
        chk("rst_stall_id", 32'(stall_id), 32'h0);
        step(); step();
        rst_n = 1'b1;

        // Write r5, with an invalid instruction in ID
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
        step();
        chk("invalid_bubble", 32'(ex_valid), 32'h0);
        wb_we = 1'b0;
        instr_d = mk_i(5'd5, 5'd0, 16'h0010); instr_valid_d = 1'b1; cs_d = 16'hA5A5;
        step();
        chk("r5_valid", 32'(ex_valid), 32'h1);
        chk("r5_rs_data", ex_rs_data, 32'h1234_5678);
        chk("r5_rs", 32'(ex_rs), 32'd5);
        chk("r5_cs", 32'(ex_cs), 32'hA5A5);
        chk("r5_rt_data", ex_rt_data, 32'h0);
        chk("r5_imm", ex_imm, 32'h0000_0010);

        // Same-cycle write/read bypass on rt
        wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h1111_1111;
        instr_d = mk_r(5'd0, 5'd0, 5'd1);
        step();
        wb_data = 32'hDEAD_BEEF;
        instr_d = mk_r(5'd5, 5'd8, 5'd2);
        step();
        chk("byp_rt_data", ex_rt_data, 32'hDEAD_BEEF);
        chk("byp_rs_data", ex_rs_data, 32'h1234_5678);
        wb_we = 1'b0;
        instr_d = mk_r(5'd8, 5'd0, 5'd2);
        step();
        chk("r8_written", ex_rs_data, 32'hDEAD_BEEF);

        // r0 writes discarded, both bypass and array
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        instr_d = mk_r(5'd0, 5'd0, 5'd3);
        step();
        chk("r0_bypass", ex_rs_data, 32'h0);
        wb_we = 1'b0;
        step();
        chk("r0_array", ex_rs_data, 32'h0);
        ex_mem_read = 1'b1; ex_dst = 5'd0;
        #1;
        chk("r0_no_stall", 32'(stall_id), 32'h0);
        step();
        chk("r0_load_valid", 32'(ex_valid), 32'h1);

        // Load-use on rs, stall for one cycle, then release
        ex_dst = 5'd3;
        instr_d = mk_r(5'd3, 5'd4, 5'd6); cs_d = 16'h1234;
        #1;
        chk("lu_stall", 32'(stall_id), 32'h1);
        step();
        chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
        chk("lu_bubble_cs", 32'(ex_cs), 32'h0);
        ex_mem_read = 1'b0;
        #1;
        chk("lu_release_stall", 32'(stall_id), 32'h0);
        step();
        chk("lu_enter_valid", 32'(ex_valid), 32'h1);
        chk("lu_enter_rs", 32'(ex_rs), 32'd3);
        chk("lu_enter_cs", 32'(ex_cs), 32'h1234);

        // Hazard on rt, suppressed by invalid ID, suppressed by flush
        ex_mem_read = 1'b1; ex_dst = 5'd4;
        #1;
        chk("lu_rt_stall", 32'(stall_id), 32'h1);
        instr_valid_d = 1'b0;
        #1;
        chk("lu_invalid_nostall", 32'(stall_id), 32'h0);
        instr_valid_d = 1'b1; flush = 1'b1;
        #1;
        chk("lu_flush_nostall", 32'(stall_id), 32'h0);
        step();
        chk("lu_flush_valid", 32'(ex_valid), 32'h0);
        flush = 1'b0; ex_mem_read = 1'b0; ex_dst = 5'd0;

        // Hold for three cycles while instr_d changes and r10 is written
        instr_d = mk_r(5'd5, 5'd8, 5'd9); cs_d = 16'h0F0F;
        step();
        chk("pre_hold_rd", 32'(ex_rd), 32'd9);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_d = mk_r(5'(i + 1), 5'(i + 2), 5'(i + 3));
            cs_d = 16'(i);
            wb_we = (i == 0); wb_addr = 5'd10; wb_data = 32'hCAFE_0000;
            #1;
            chk("hold_stall", 32'(stall_id), 32'h1);
            step();
            chk("hold_valid", 32'(ex_valid), 32'h1);
            chk("hold_rs", 32'(ex_rs), 32'd5);
            chk("hold_rd", 32'(ex_rd), 32'd9);
            chk("hold_cs", 32'(ex_cs), 32'h0F0F);
            chk("hold_rt_data", ex_rt_data, 32'hDEAD_BEEF);
        end
        hold = 1'b0; wb_we = 1'b0;
        instr_d = mk_r(5'd10, 5'd0, 5'd7); cs_d = 16'h7777;
        step();
        chk("rel_rs", 32'(ex_rs), 32'd10);
        chk("rel_rd", 32'(ex_rd), 32'd7);
        chk("rel_r10_data", ex_rs_data, 32'hCAFE_0000);
        flush = 1'b1;
        step();
        chk("flush_valid", 32'(ex_valid), 32'h0);
        chk("flush_cs", 32'(ex_cs), 32'h0);
        flush = 1'b0;
        step();
        hold = 1'b1; flush = 1'b1;
        step();
        chk("hold_flush_valid", 32'(ex_valid), 32'h1);
        chk("hold_flush_cs", 32'(ex_cs), 32'h7777);
        hold = 1'b0; flush = 1'b0;

        // Immediate extension and jump index
        instr_d = {6'h08, 5'd1, 5'd2, 16'h8001};
        step();
        chk("imm_sext", ex_imm, 32'hFFFF_8001);
        chk("imm_zext", z_ex_imm, 32'h0000_8001);
        chk("index", 32'(ex_index), 32'h0022_8001);
        chk("imm_rt", 32'(ex_rt), 32'd2);

        // Asynchronous reset mid-hazard
        ex_mem_read = 1'b1; ex_dst = 5'd2;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'h0);
        chk("arst_imm", ex_imm, 32'h0);
        chk("arst_stall_comb", 32'(stall_id), 32'h1);
        #2;
        rst_n = 1'b1;
        ex_mem_read = 1'b0; ex_dst = 5'd0;
        instr_d = mk_r(5'd5, 5'd8, 5'd1);
        step();
        chk("arst_r5_cleared", ex_rs_data, 32'h0);
        chk("arst_r8_cleared", ex_rt_data, 32'h0);
        chk("arst_after_valid", 32'(ex_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the MIPS pipeline.
- Extracts the instruction fields and reads a multi-entry register file, with write-back-to-decode bypass.
- Detects load-use hazards and inserts bubbles.
- Registers everything into an ID/EX pipeline register with valid, hold and flush control.
- Sits between the IF/ID register and the EX stage; the control unit is external and its signals pass through on cs_d.

Parameters:
- DATA_W, 32, datapath and instruction width (must be 32 for MIPS field positions).
- REG_AD, 5, register address width; register count is 2**REG_AD.
- CS_W, 16, width of the control-signal bundle passed through.
- SEXT_IMM, 1, 1 = ex_imm is the sign-extended imm16; 0 = zero-extended.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_d  in  DATA_W  instruction in ID.
- instr_valid_d  in  1  instr_d holds a real instruction.
- cs_d  in  CS_W  decoded control for instr_d.
- wb_we  in  1  write-back enable.
- wb_addr  in  REG_AD  write-back destination.
- wb_data  in  DATA_W  write-back data.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_dst  in  REG_AD  destination register of the instruction in EX.
- hold  in  1  downstream stall; freeze ID/EX.
- flush  in  1  squash the instruction in ID (branch/jump redirect).
- stall_id  out  1  combinational; IF/ID and PC must hold this cycle.
- ex_valid  out  1  ID/EX contains a real instruction.
- ex_cs  out  CS_W  registered cs_d.
- ex_rs_data  out  DATA_W  registered rs operand.
- ex_rt_data  out  DATA_W  registered rt operand.
- ex_rs  out  REG_AD  registered rs field.
- ex_rt  out  REG_AD  registered rt field.
- ex_rd  out  REG_AD  registered rd field.
- ex_imm  out  DATA_W  registered extended immediate.
- ex_index  out  26  registered jump index, instr[25:0].

Behaviour:
- Fields: rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], imm16 = instr[15:0], index = instr[25:0]. When REG_AD > 5, addresses are zero-padded.
- Register file: 2**REG_AD x DATA_W, cleared to 0 by reset.
  - Write on the rising clk edge when wb_we = 1 and wb_addr != 0.
  - Writes to r0 are discarded; r0 always reads 0.
  - Writes occur regardless of hold, flush or stall.
- Read bypass (combinational): if wb_we = 1, wb_addr != 0 and wb_addr == rs, rs data = wb_data; otherwise it is the array value. Same rule for rt. Result: same-cycle write/read returns the new value.
- hazard = instr_valid_d & ex_mem_read & (ex_dst != 0) & ((ex_dst == rs) | (ex_dst == rt)). Both fields are compared conservatively.
- stall_id = hold | (hazard & ~flush).
- ID/EX update on each rising edge, in priority order:
  1. hold = 1: all ex_* registers keep their values, including ex_valid.
  2. flush = 1: ex_valid <= 0; other ex_* are don't-care, and the implementation loads zeros.
  3. hazard = 1: bubble; ex_valid <= 0 and ex_cs <= 0. The instruction stays in ID (stall_id = 1) and re-evaluates next cycle.
  4. Otherwise: ex_valid <= instr_valid_d; all fields, bypassed read data, cs_d and the extended immediate are loaded.
- hold together with flush: hold wins for ID/EX. The upstream flush is still seen by IF/ID, and the ID instruction is lost. The stage owner guarantees that pairing is legal.
- Latency: 1 cycle from instr_d to ex_*; stall_id has zero latency.
- Reset: async assert; all ex_* = 0, ex_valid = 0, all registers = 0. stall_id follows its inputs combinationally. Reset mid-hazard drops the bubble and the held state.
- Invalid ID (instr_valid_d = 0): no hazard is raised, and a bubble propagates to EX.

Test Plan:
- Reset, then write r5 = 0x12345678 with wb_we. Next cycle decode rs = 5 -> ex_rs_data = 0x12345678 and ex_valid = 1 one cycle later.
- Same-cycle bypass: wb_we = 1, wb_addr = 8, wb_data = 0xDEADBEEF while instr_d has rt = 8 -> ex_rt_data = 0xDEADBEEF, not the old r8.
- r0: write wb_addr = 0 with data 0xFFFFFFFF, then read rs = 0 -> ex_rs_data = 0. A load in EX with ex_dst = 0 -> stall_id = 0.
- Load-use: ex_mem_read = 1, ex_dst = 3, instr_d rs = 3. Cycle 1: stall_id = 1 and ex_valid <= 0. Cycle 2 with ex_mem_read = 0: stall_id = 0 and the instruction enters EX with ex_valid = 1.
- Hold for 3 cycles with a changing instr_d -> ex_* stay constant and stall_id = 1. After release the current instr_d loads. Flush -> ex_valid = 0 the next cycle.
- Immediate: instr imm16 = 0x8001 -> ex_imm = 0xFFFF8001 with SEXT_IMM = 1 and 0x00008001 with SEXT_IMM = 0. ex_index = instr[25:0].
